// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// No logic, so no latency or backpressure of its own.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size code: 0 byte, 1 half, 2 word (3 never legal).
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    return f3[1:0];
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Word-wide data bus between the LSU (master) and the RAM/bus fabric (slave).
// Request fields are registered by the master; the slave completes with a one-cycle bus_ready strobe.
interface data_mem_lsu_if;
  import lsu_pkg::*;

  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_ready;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ready
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane formatter: store byte enables/replication, access legality checks, load extraction.
// Purely combinational, zero latency; no flow control.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            i_we,
  input  logic            i_re,
  input  logic [2:0]      i_func3,
  input  logic [1:0]      i_lane,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rword,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_illegal,
  output logic            o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    o_be    = 4'b0000;
    o_wdata = '0;
    case (i_func3)
      F3_SB: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_SH: begin
        o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_SW: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: ;
    endcase

    o_rdata = '0;
    case (i_func3)
      F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      F3_LW:   o_rdata = i_rword;
      F3_LBU:  o_rdata = {24'h000000, w_byte};
      F3_LHU:  o_rdata = {16'h0000, w_half};
      default: ;
    endcase

    // Stores allow only 000/001/010; loads reject 011/110/111.
    o_illegal = (i_we & i_re)
              | (i_we & (i_func3[2] | (i_func3[1:0] == 2'b11)))
              | (i_re & ((i_func3[1:0] == 2'b11) | (i_func3[2:1] == 2'b11)));
    o_misaligned = ((f3_size(i_func3) == 2'b01) & i_lane[0])
                 | ((f3_size(i_func3) == 2'b10) & (i_lane != 2'b00));
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the core data port and a word bus; 2-cycle minimum stall (request + one BUSY).
// Stall is held while the bus withholds bus_ready; aborts with a timeout error after TIMEOUT_CYCLES.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dataWe,
  input  logic            dataRe,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] dataAddr,
  input  logic [XLEN-1:0] dataWData,
  output logic [XLEN-1:0] dataRData,
  output logic            stall,
  output logic            lsu_err,
  output logic [1:0]      err_cause,
  data_mem_lsu_if.master  bus
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t      r_state, w_state_nxt;
  logic            r_bus_req, r_bus_we;
  logic [XLEN-1:0] r_bus_addr, r_bus_wdata, r_rdata;
  logic [3:0]      r_bus_be;
  logic            r_lsu_err;
  logic [1:0]      r_err_cause;
  logic [15:0]     r_cnt;
  logic [2:0]      r_func3;
  logic [1:0]      r_lane;
  logic            r_is_load;

  logic            w_access, w_err, w_timeout;
  logic [2:0]      w_al_func3;
  logic [1:0]      w_al_lane;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_ld_data;
  logic            w_illegal, w_misaligned;

  // One formatter serves both ends: live inputs for launch checks, latched launch info in DONE.
  assign w_al_func3 = (r_state == DONE) ? r_func3 : func3;
  assign w_al_lane  = (r_state == DONE) ? r_lane  : dataAddr[1:0];

  lsu_align u_align (
    .i_we        (dataWe),
    .i_re        (dataRe),
    .i_func3     (w_al_func3),
    .i_lane      (w_al_lane),
    .i_wdata     (dataWData),
    .i_rword     (r_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata     (w_ld_data),
    .o_illegal   (w_illegal),
    .o_misaligned(w_misaligned)
  );

  assign w_access  = dataWe | dataRe;
  assign w_err     = w_illegal | w_misaligned;
  assign w_timeout = ~bus.bus_ready & (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    dataRData   = '0;
    case (r_state)
      IDLE: begin
        if (w_access & ~w_err) begin
          stall       = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.bus_ready | w_timeout) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
        if (r_is_load) dataRData = w_ld_data;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
      r_lsu_err   <= 1'b0;
      r_err_cause <= ERR_NONE;
      r_cnt       <= 16'd0;
      r_func3     <= 3'b000;
      r_lane      <= 2'b00;
      r_is_load   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lsu_err   <= 1'b0;
      r_err_cause <= ERR_NONE;
      case (r_state)
        IDLE: begin
          if (w_access & w_err) begin
            r_lsu_err   <= 1'b1;
            r_err_cause <= w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
          end else if (w_access) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= dataWe;
            r_bus_addr  <= {dataAddr[XLEN-1:2], 2'b00};
            r_bus_be    <= dataWe ? w_be : 4'b0000;
            r_bus_wdata <= dataWe ? w_wdata : '0;
            r_func3     <= func3;
            r_lane      <= dataAddr[1:0];
            r_is_load   <= dataRe;
            r_cnt       <= 16'd0;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 16'd1;
          if (bus.bus_ready) begin
            r_rdata   <= bus.bus_rdata;
            r_bus_req <= 1'b0;
          end else if (w_timeout) begin
            r_rdata     <= '0;
            r_bus_req   <= 1'b0;
            r_lsu_err   <= 1'b1;
            r_err_cause <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;
  assign lsu_err       = r_lsu_err;
  assign err_cause     = r_err_cause;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed cases then randomized accesses against an arithmetic reference model.
// Acts as the bus slave, returning bus_ready after a chosen number of BUSY cycles (or never, to force timeout).
module tb_data_mem_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dataWe, dataRe;
  logic [2:0]  func3;
  logic [31:0] dataAddr, dataWData, dataRData;
  logic        stall, lsu_err;
  logic [1:0]  err_cause;

  int n_chk  = 0;
  int n_fail = 0;

  data_mem_lsu_if bus_if ();

  data_mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .dataWe   (dataWe),
    .dataRe   (dataRe),
    .func3    (func3),
    .dataAddr (dataAddr),
    .dataWData(dataWData),
    .dataRData(dataRData),
    .stall    (stall),
    .lsu_err  (lsu_err),
    .err_cause(err_cause),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // 0 legal, 1 misaligned, 2 illegal
  function automatic logic [1:0] ref_cause(input logic we, input logic re, input logic [2:0] f3,
                                           input logic [31:0] addr);
    int unsigned size;
    if (we && re) return 2'd2;
    if (we && f3 > 3'd2) return 2'd2;
    if (re && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'd2;
    size = 1 << (f3 % 4);
    if (addr % size != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v, b, h;
    v = word >> (8 * (addr % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd2:    return word;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_access(input logic we, input logic re, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] word, input int delay);
    logic [1:0]  cause;
    int unsigned size;
    logic [31:0] exp_be, exp_wd, exp_rd;
    bit          timeout;
    cause = ref_cause(we, re, f3, addr);
    @(posedge clk); #1;
    dataWe = we; dataRe = re; func3 = f3; dataAddr = addr; dataWData = wd;
    bus_if.bus_ready = 1'b0;
    @(negedge clk);
    chk("req_stall", stall, {31'd0, cause == 2'd0});
    chk("req_rdata", dataRData, 32'h0);
    if (cause != 2'd0) begin
      @(posedge clk); #1;
      dataWe = 1'b0; dataRe = 1'b0;
      @(negedge clk);
      chk("err_pulse", lsu_err, 32'd1);
      chk("err_cause", err_cause, cause);
      chk("err_no_req", bus_if.bus_req, 32'd0);
      chk("err_stall", stall, 32'd0);
      chk("err_rdata", dataRData, 32'h0);
      return;
    end
    size    = 1 << (f3 % 4);
    exp_be  = we ? ((1 << size) - 1) << (addr % 4) : 32'h0;
    exp_wd  = !we ? 32'h0 : (size == 1) ? (wd & 32'hFF) * 32'h01010101
            : (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    timeout = (delay >= TO);
    for (int k = 0; k < TO; k++) begin
      @(posedge clk); #1;
      bus_if.bus_ready = (k == delay);
      bus_if.bus_rdata = (k == delay) ? word : $urandom;
      @(negedge clk);
      chk("busy_req", bus_if.bus_req, 32'd1);
      chk("busy_stall", stall, 32'd1);
      chk("busy_rdata", dataRData, 32'h0);
      chk("busy_err", lsu_err, 32'd0);
      if (k == 0) begin
        chk("bus_addr", bus_if.bus_addr, addr & 32'hFFFFFFFC);
        chk("bus_we", bus_if.bus_we, {31'd0, we});
        chk("bus_be", bus_if.bus_be, exp_be);
        chk("bus_wdata", bus_if.bus_wdata, exp_wd);
      end
      if (k == delay) break;
    end
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = $urandom;
    @(negedge clk);
    exp_rd = (re && !timeout) ? ref_load(f3, addr, word) : 32'h0;
    chk("done_stall", stall, 32'd0);
    chk("done_req", bus_if.bus_req, 32'd0);
    chk("done_err", lsu_err, {31'd0, timeout});
    if (timeout) chk("done_cause", err_cause, 32'd3);
    chk("done_rdata", dataRData, exp_rd);
    @(posedge clk); #1;
    dataWe = 1'b0; dataRe = 1'b0;
    @(negedge clk);
    chk("idle_stall", stall, 32'd0);
    chk("idle_err", lsu_err, 32'd0);
    chk("idle_rdata", dataRData, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we, re;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          sel;
    reset = 1'b1; dataWe = 1'b0; dataRe = 1'b0; func3 = 3'b000;
    dataAddr = 32'h0; dataWData = 32'h0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus_if.bus_req, 32'd0);
    chk("rst_we", bus_if.bus_we, 32'd0);
    chk("rst_addr", bus_if.bus_addr, 32'h0);
    chk("rst_be", bus_if.bus_be, 32'h0);
    chk("rst_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst_err", lsu_err, 32'd0);
    chk("rst_cause", err_cause, 32'd0);
    chk("rst_stall", stall, 32'd0);
    chk("rst_rdata", dataRData, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Stray bus_ready while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_if.bus_ready = 1'b1; bus_if.bus_rdata = $urandom;
      @(negedge clk);
      chk("idle_ready_req", bus_if.bus_req, 32'd0);
      chk("idle_ready_stall", stall, 32'd0);
    end
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b0;

    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0);
    run_access(1'b0, 1'b1, 3'b000, 32'h102, 32'h0, 32'h12803456, 0);
    run_access(1'b0, 1'b1, 3'b100, 32'h102, 32'h0, 32'h12803456, 1);
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 32'h12803456, 2);
    run_access(1'b0, 1'b1, 3'b101, 32'h100, 32'h0, 32'h12803456, 0);
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 0);
    run_access(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    run_access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
    run_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    run_access(1'b0, 1'b1, 3'b110, 32'h100, 32'h0, 32'h0, 0);
    run_access(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0);
    run_access(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, TO - 1);
    run_access(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, 99);
    run_access(1'b1, 1'b0, 3'b010, 32'h304, 32'h01234567, 32'h0, 99);

    // Reset in the middle of a BUSY access.
    @(posedge clk); #1;
    dataWe = 1'b0; dataRe = 1'b1; func3 = 3'b010; dataAddr = 32'h200;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy_req_before", bus_if.bus_req, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; dataRe = 1'b0;
    @(negedge clk);
    chk("rst_busy_req", bus_if.bus_req, 32'd0);
    chk("rst_busy_stall", stall, 32'd0);
    chk("rst_busy_err", lsu_err, 32'd0);
    run_access(1'b1, 1'b0, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 1);

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      we  = (sel >= 5);
      re  = (sel <= 4) || (sel == 9);
      f3  = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      run_access(we, re, f3, addr, $urandom, $urandom, $urandom_range(0, TO + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
